vid_mem_arbiter: RTL
====================

Name: vid_mem_arbiter

Overview:
- Shares the single-port, synchronous-read world-map/frame RAM between the display pixel pipeline and the CPU bus.
- The display pipeline is driven by the 1024x768 timing generator (pixel_row/pixel_column/video_on). It has absolute priority and a fixed read latency.
- The CPU uses a req/ack handshake and is served in slots the display does not use. Optionally CPU access is restricted to blanking.
- Sits between the timing/pixel-fetch logic, the CPU I/O bridge and the RAM port.

Parameters:
ADDR_W, 14, RAM address width (128x128 map)
DATA_W, 8, RAM data width
CPU_BLANK_ONLY, 0, 1 = issue CPU accesses only while video_on=0

Ports:
clock  in  1  75 MHz pixel clock
rst  in  1  asynchronous, active-high reset
video_on  in  1  active-video flag from timing generator
disp_req  in  1  display read request, single-cycle, may assert every cycle
disp_addr  in  ADDR_W  display read address, valid with disp_req
disp_rvalid  out  1  display read data valid, 1-cycle pulse
disp_rdata  out  DATA_W  display read data
cpu_req  in  1  CPU request, held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
cpu_ack  out  1  1-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack (read)
ram_en  out  1  RAM port enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid one edge after RAM samples address

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0.
  - The FSM goes to IDLE.
  - The tag pipeline is cleared, so in-flight reads are dropped.
  - No ack or rvalid is generated for requests pending at reset.
- Slot decision at every edge, exactly one issue per edge:
  - If disp_req=1, issue a display read: ram_en=1, ram_we=0, ram_addr=disp_addr.
  - Else, if FSM=IDLE and cpu_req=1 and (CPU_BLANK_ONLY=0 or video_on=0), issue the CPU access.
  - Otherwise ram_en=0 and ram_we=0.
- Display read latency: disp_req sampled at edge N gives disp_rvalid=1 after edge N+2. disp_rdata is registered from ram_rdata at that edge.
- Tag pipeline: a 2-stage shift of {valid, is_disp} follows every read issue. At each edge, stage-2 decides whether ram_rdata goes to disp_rdata+disp_rvalid or to cpu_rdata+cpu_ack. Display and CPU reads may interleave freely.
- FSM states:
  - IDLE
  - RD_PEND1
  - RD_PEND2
  - ACK
- FSM transitions:
  - IDLE→ACK: a CPU write is issued at edge N. ram_we=1 and cpu_ack=1 after N.
  - IDLE→RD_PEND1: a CPU read is issued at N.
  - RD_PEND1→RD_PEND2 at N+1.
  - RD_PEND2→ACK at N+2. cpu_rdata is captured and cpu_ack=1.
  - ACK→IDLE unconditionally, without sampling cpu_req, so a held request cannot issue twice.
- Display issue never waits on the FSM. A CPU access whose slot is taken by disp_req stays pending in IDLE with no timeout.
- cpu_ack is never asserted in two consecutive cycles. disp_rvalid may assert every cycle.
- The CPU sees at most one outstanding access.
- The arbiter never modifies addresses or data. Widths pass through unchanged.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds input stats_clr and output cpu_wait_max[15:0].
  - A wait counter increments each cycle the FSM is IDLE with cpu_req=1 and no CPU issue.
  - The counter clears on CPU issue.
  - cpu_wait_max holds the saturating maximum, stopping at 0xFFFF.
  - stats_clr=1 zeroes both the counter and cpu_wait_max.
  - Reset zeroes both.
- Undefined: none of these ports or logic exist, and behaviour is otherwise identical.

Test Plan:
- Reset mid CPU read (rst pulse at RD_PEND1) -> all outputs 0, no cpu_ack afterward, next request served normally.
- disp_req every cycle, addrs 0..7, RAM preloaded with data=addr -> disp_rvalid continuous from edge 2, disp_rdata 0..7 in order; cpu_req held throughout gets no issue.
- CPU write addr 0x0123 data 0xA5, then read 0x0123, no display traffic -> ram_we pulse 1 cycle; write ack 1 cycle after issue; read ack 2 edges after issue with cpu_rdata=0xA5.
- CPU read issued at N, disp_req at N+1 addr 0x0010 (data 0x3C) -> cpu_ack at N+2 with CPU data; disp_rvalid at N+3 with 0x3C; no cross-routing.
- CPU_BLANK_ONLY=1, cpu_req held while video_on=1 for 100 cycles then 0 -> no issue until first edge with video_on=0; exactly one ack.
- ARB_STATS_EN: block CPU 40 cycles via disp_req, then release -> cpu_wait_max=40; stats_clr -> 0.

Source files
------------

// File: rtl/vid_mem_arbiter.sv
// Arbitrates the single-port map/frame RAM between the display fetch (absolute priority) and the CPU bus.
// Optional wait statistics (stats_clr, cpu_wait_max) are compiled in with `define ARB_STATS_EN.
module vid_mem_arbiter #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 8,
  parameter int CPU_BLANK_ONLY = 0
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              video_on,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       cpu_wait_max
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PEND1 = 2'd1,
    RD_PEND2 = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t state;

  logic cpu_allowed;
  logic cpu_issue;

  logic tag1_valid, tag1_disp;
  logic tag2_valid, tag2_disp;

  assign cpu_allowed = (CPU_BLANK_ONLY == 0) || !video_on;
  assign cpu_issue   = !disp_req && (state == IDLE) && cpu_req && cpu_allowed;

  // FSM and registered RAM command; ACK always returns to IDLE so a held request cannot reissue
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;

      if (disp_req) begin
        ram_en   <= 1'b1;
        ram_addr <= disp_addr;
      end else if (cpu_issue) begin
        ram_en    <= 1'b1;
        ram_we    <= cpu_we;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end

      case (state)
        IDLE: begin
          if (cpu_issue) begin
            if (cpu_we) begin
              state   <= ACK;
              cpu_ack <= 1'b1;
            end else begin
              state <= RD_PEND1;
            end
          end
        end
        RD_PEND1: state <= RD_PEND2;
        RD_PEND2: begin
          state   <= ACK;
          cpu_ack <= 1'b1;
        end
        ACK:      state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Read tags follow each read issue; stage 2 lines up with ram_rdata for routing
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tag1_valid  <= 1'b0;
      tag1_disp   <= 1'b0;
      tag2_valid  <= 1'b0;
      tag2_disp   <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      cpu_rdata   <= '0;
    end else begin
      tag1_valid  <= disp_req || (cpu_issue && !cpu_we);
      tag1_disp   <= disp_req;
      tag2_valid  <= tag1_valid;
      tag2_disp   <= tag1_disp;
      disp_rvalid <= tag2_valid && tag2_disp;
      if (tag2_valid && tag2_disp) begin
        disp_rdata <= ram_rdata;
      end
      if (tag2_valid && !tag2_disp) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;
  logic        wait_inc;

  assign wait_inc     = (state == IDLE) && cpu_req && !cpu_issue;
  assign wait_cnt_nxt = (wait_cnt == 16'hFFFF) ? 16'hFFFF : wait_cnt + 16'd1;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      cpu_wait_max <= '0;
    end else if (stats_clr) begin
      wait_cnt     <= '0;
      cpu_wait_max <= '0;
    end else if (cpu_issue) begin
      wait_cnt <= '0;
    end else if (wait_inc) begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt > cpu_wait_max) begin
        cpu_wait_max <= wait_cnt_nxt;
      end
    end
  end
`endif

endmodule
